// File: rtl/serial_word_pkg.sv
// Shared types and defaults for the serial word transmitter.
package serial_word_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } swt_state_e;

  localparam int SWT_WIDTH = 8;
  localparam int SWT_GAP   = 1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register with captured bit-order select.
// nxt_bit is the bit that will sit at the output end after this edge,
// so the parent can register it straight into its ser_d flop.
module piso_shift_reg
  import serial_word_pkg::*;
#(
  parameter int WIDTH = SWT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  input  logic             msb_first,
  output logic             nxt_bit
);

  logic [WIDTH-1:0] sr, sr_nxt;
  logic             ord, ord_nxt;

  // next register contents: load wins, otherwise shift toward the output end
  always_comb begin
    sr_nxt  = sr;
    ord_nxt = ord;
    if (load) begin
      sr_nxt  = data;
      ord_nxt = msb_first;
    end else if (shift) begin
      sr_nxt = ord ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
    end
    nxt_bit = ord_nxt ? sr_nxt[WIDTH-1] : sr_nxt[0];
  end

  // shift register and order flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      ord <= 1'b0;
    end else begin
      sr  <= sr_nxt;
      ord <= ord_nxt;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Word-to-serial transmitter: accepts a word in IDLE, emits WIDTH bits
// with ser_en high, pulses done on the last bit, then idles GAP_CYCLES.
module serial_word_tx
  import serial_word_pkg::*;
#(
  parameter int WIDTH      = SWT_WIDTH,
  parameter int GAP_CYCLES = SWT_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  output logic             in_ready,
  output logic             ser_en,
  output logic             ser_d,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  swt_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   gcnt;
  logic            accept, bit_go, nxt_bit;

  assign accept = in_valid && (state == IDLE);
  // a bit goes out next cycle on acceptance and on every SHIFT edge but the last
  assign bit_go = accept || ((state == SHIFT) && (cnt != CNT_LAST));

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (state == SHIFT),
    .data      (in_data),
    .msb_first (msb_first),
    .nxt_bit   (nxt_bit)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gcnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded handshake outputs
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // bit counter: index of the bit currently on ser_d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (accept)          cnt <= '0;
    else if (state == SHIFT)  cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
  end

  // gap counter: cycles spent in GAP so far
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             gcnt <= '0;
    else if (state == GAP)  gcnt <= (gcnt == GAP_LAST) ? '0 : gcnt + GW'(1);
    else                    gcnt <= '0;
  end

  // registered serial outputs; ser_d forced low whenever ser_en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_en <= 1'b0;
      ser_d  <= 1'b0;
      done   <= 1'b0;
    end else begin
      ser_en <= bit_go;
      ser_d  <= bit_go & nxt_bit;
      done   <= (state == SHIFT) && (cnt == CNT_PEN);
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: an 8-bit/gap-1 and a 4-bit/gap-0 instance.
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid8, msb8, in_valid4, msb4;
  logic [7:0] in_data8;
  logic [3:0] in_data4;
  logic       in_ready8, ser_en8, ser_d8, busy8, done8;
  logic       in_ready4, ser_en4, ser_d4, busy4, done4;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(8), .GAP_CYCLES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_data(in_data8),
    .msb_first(msb8), .in_ready(in_ready8), .ser_en(ser_en8), .ser_d(ser_d8),
    .busy(busy8), .done(done8)
  );

  serial_word_tx #(.WIDTH(4), .GAP_CYCLES(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data4),
    .msb_first(msb4), .in_ready(in_ready4), .ser_en(ser_en4), .ser_d(ser_d4),
    .busy(busy4), .done(done4)
  );

  // status vector {ser_en, ser_d, done, busy, in_ready}
  function automatic logic [4:0] obs(input bit u);
    return u ? {ser_en4, ser_d4, done4, busy4, in_ready4}
             : {ser_en8, ser_d8, done8, busy8, in_ready8};
  endfunction

  task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (en,d,done,busy,ready)", tag, o, e);
    end
  endtask

  task automatic drive(input bit u, input logic v, input logic [7:0] d, input logic m);
    if (u) begin in_valid4 = v; in_data4 = d[3:0]; msb4 = m; end
    else   begin in_valid8 = v; in_data8 = d;      msb8 = m; end
  endtask

  // Send one word from a negedge with the block idle; check every bit,
  // the gap and the idle slot. keep leaves in_valid high for back-to-back.
  task automatic send(input bit u, input logic [7:0] d, input logic msb,
                      input bit keep, input bit perturb);
    int   w = u ? 4 : 8;
    int   g = u ? 0 : 1;
    logic eb;
    drive(u, 1'b1, d, msb);
    chk("ready_before_word", obs(u), 5'b00001);
    @(posedge clk);
    #1 if (!keep) drive(u, 1'b0, d, msb);
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      eb = d[msb ? (w - 1 - k) : k];
      chk($sformatf("bit%0d_of_%h", k, d), obs(u), {1'b1, eb, (k == w - 1), 1'b1, 1'b0});
      if (perturb) drive(u, 1'($urandom_range(1)), 8'($urandom), ~msb);
    end
    drive(u, 1'(keep), d, msb);
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      chk("gap", obs(u), 5'b00010);
    end
    @(negedge clk);
    chk("idle_slot", obs(u), 5'b00001);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    #2;
    chk("reset8", obs(0), 5'b00001);
    chk("reset4", obs(1), 5'b00001);
    @(negedge clk);
    rst_n = 1'b1;

    // directed words on the 8-bit instance, first one right after reset
    send(0, 8'h1E, 1'b0, 0, 0);
    send(0, 8'h1E, 1'b1, 0, 0);
    send(0, 8'hFF, 1'b0, 1, 0);
    send(0, 8'h00, 1'b0, 0, 0);
    send(0, 8'h5A, 1'b0, 0, 1);
    send(0, 8'hC3, 1'b1, 0, 1);

    // reset after the third bit discards the word
    drive(0, 1'b1, 8'hA5, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'hA5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pre_reset_bit", obs(0), {1'b1, 1'(8'hA5 >> k), 1'b0, 1'b1, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_word", obs(0), 5'b00001);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("held_in_reset", obs(0), 5'b00001);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("quiet_after_reset", obs(0), 5'b00001);
    end
    send(0, 8'h3C, 1'b1, 0, 0);

    // random words, 8-bit instance
    for (int i = 0; i < 8; i++)
      send(0, 8'($urandom), 1'($urandom_range(1)),
           (i < 7) ? bit'($urandom_range(1)) : 1'b0, bit'($urandom_range(1)));

    // zero-gap 4-bit instance: back-to-back then random
    send(1, 8'h09, 1'b1, 1, 0);
    send(1, 8'h06, 1'b0, 1, 1);
    send(1, 8'h0B, 1'b1, 0, 0);
    for (int i = 0; i < 6; i++)
      send(1, 8'($urandom), 1'($urandom_range(1)),
           (i < 5) ? bit'($urandom_range(1)) : 1'b0, bit'($urandom_range(1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
